line_fetch: RTL and testbench

LINE_FETCH -- requirements
Module: line_fetch

---
 rtl/fb_pkg.sv | 34 +++
 rtl/line_fetch_pix_unpack.sv | 129 ++++++++++++
 rtl/line_fetch.sv | 176 +++++++++++++++++
 tb/tb_line_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer line-fetch definitions: word/pixel geometry helpers,
// AXI burst constants and the fetch FSM state type.
package fb_pkg;

  localparam int unsigned MAX_BURST      = 16;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StAddr,
    StData
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned pixs_per_word(input int unsigned data_width,
                                                input int unsigned bytes_per_pix);
    return (data_width / 8) / bytes_per_pix;
  endfunction

  function automatic int unsigned stride(input int unsigned img_width,
                                         input int unsigned bytes_per_pix);
    return img_width * bytes_per_pix;
  endfunction

  // Lane index width; at least one bit so a one-pixel word still has a legal index.
  function automatic int unsigned lane_width(input int unsigned pixs);
    return (pixs > 1) ? $clog2(pixs) : 1;
  endfunction

endpackage

// File: rtl/line_fetch_pix_unpack.sv
// Single-word R-data buffer plus lane serializer. The first word of a line
// starts at lane i_skip; the buffer empties after its last kept lane or after
// the line's final pixel, so trailing lanes of the last word are dropped.
// Optional LINE_FETCH_OUTREG_EN: a 2-entry skid register drives o_pix_*.
module line_fetch_pix_unpack #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned PIX_WIDTH  = 32,
  parameter int unsigned LANE_W     = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [LANE_W-1:0]     i_skip,
  input  logic [15:0]           i_count,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic [PIX_WIDTH-1:0]  o_pix_data,
  output logic                  o_pix_valid,
  output logic                  o_pix_last,
  input  logic                  i_pix_ready
);

  localparam int unsigned PIXS = DATA_WIDTH / PIX_WIDTH;

  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_full;
  logic                  r_first;
  logic [LANE_W-1:0]     r_lane;
  logic [LANE_W-1:0]     r_skip;
  logic [15:0]           r_left;

  logic [PIX_WIDTH-1:0]  w_str_data;
  logic                  w_str_valid;
  logic                  w_str_last;
  logic                  w_str_ready;
  logic                  w_take;
  logic                  w_buf_end;
  logic                  w_load;

  assign w_str_valid  = r_full;
  assign w_str_data   = r_buf[r_lane*PIX_WIDTH +: PIX_WIDTH];
  assign w_str_last   = (r_left == 16'd1);
  assign w_take       = w_str_valid && w_str_ready;
  assign w_buf_end    = (r_lane == LANE_W'(PIXS - 1)) || (r_left == 16'd1);
  // Refill in the same cycle the last kept lane leaves, for one pixel per clock.
  assign o_word_ready = !r_full || (w_take && w_buf_end);
  assign w_load       = i_word_valid && o_word_ready;

  // Buffer, lane pointer and remaining-pixel count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_first <= 1'b0;
      r_lane  <= '0;
      r_skip  <= '0;
      r_left  <= '0;
    end else if (i_start) begin
      r_skip  <= i_skip;
      r_left  <= i_count;
      r_first <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_take) begin
        r_left <= r_left - 16'd1;
        r_lane <= r_lane + LANE_W'(1);
      end
      if (w_load) begin
        r_buf   <= i_word;
        r_full  <= 1'b1;
        r_lane  <= r_first ? r_skip : '0;
        r_first <= 1'b0;
      end else if (w_take && w_buf_end) begin
        r_full <= 1'b0;
      end
    end
  end

`ifdef LINE_FETCH_OUTREG_EN
  logic                 r_out_v;
  logic                 r_out_last;
  logic [PIX_WIDTH-1:0] r_out_d;
  logic                 r_sk_v;
  logic                 r_sk_last;
  logic [PIX_WIDTH-1:0] r_sk_d;

  assign w_str_ready = !r_sk_v;

  // Output register with one skid entry so upstream ready is itself registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_v    <= 1'b0;
      r_out_last <= 1'b0;
      r_out_d    <= '0;
      r_sk_v     <= 1'b0;
      r_sk_last  <= 1'b0;
      r_sk_d     <= '0;
    end else if (!r_out_v || i_pix_ready) begin
      if (r_sk_v) begin
        r_out_v    <= 1'b1;
        r_out_d    <= r_sk_d;
        r_out_last <= r_sk_last;
        r_sk_v     <= 1'b0;
      end else begin
        r_out_v <= w_str_valid;
        if (w_str_valid) begin
          r_out_d    <= w_str_data;
          r_out_last <= w_str_last;
        end
      end
    end else if (w_str_valid && !r_sk_v) begin
      r_sk_v    <= 1'b1;
      r_sk_d    <= w_str_data;
      r_sk_last <= w_str_last;
    end
  end

  assign o_pix_valid = r_out_v;
  assign o_pix_data  = r_out_d;
  assign o_pix_last  = r_out_last;
`else
  assign w_str_ready = i_pix_ready;
  assign o_pix_valid = w_str_valid;
  assign o_pix_data  = w_str_data;
  assign o_pix_last  = w_str_last;
`endif

endmodule

// File: rtl/line_fetch.sv
// Framebuffer line fetcher: turns (base, x, y, w) requests into AXI INCR read
// bursts (max 16 beats, never crossing 4 KB) and streams the w requested
// pixels. Define LINE_FETCH_OUTREG_EN to register the pix_* outputs.
module line_fetch
  import fb_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned IMG_WIDTH      = 1920,
  parameter int unsigned BYTES_PER_PIX  = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_base_addr,
  input  logic [15:0]                 req_x,
  input  logic [15:0]                 req_y,
  input  logic [15:0]                 req_w,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic [8*BYTES_PER_PIX-1:0]  pix_data,
  output logic                        pix_valid,
  output logic                        pix_last,
  input  logic                        pix_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]                  axi_arlen,
  output logic [2:0]                  axi_arsize,
  output logic [1:0]                  axi_arburst,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic                        axi_rlast,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
);

  localparam int unsigned BPW       = bytes_per_word(AXI_DATA_WIDTH);
  localparam int unsigned PIXS      = pixs_per_word(AXI_DATA_WIDTH, BYTES_PER_PIX);
  localparam int unsigned PIX_WIDTH = 8 * BYTES_PER_PIX;
  localparam int unsigned LANE_W    = lane_width(PIXS);
  localparam int unsigned SIZE      = $clog2(BPW);
  localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE_A =
      AXI_ADDR_WIDTH'(stride(IMG_WIDTH, BYTES_PER_PIX));
  localparam logic [AXI_ADDR_WIDTH-1:0] BPP_A      = AXI_ADDR_WIDTH'(BYTES_PER_PIX);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BPW - 1);

  state_t                    r_state, w_state_nxt;
  logic                      r_req_ready;
  logic [AXI_ADDR_WIDTH-1:0] r_base;
  logic [15:0]               r_x, r_y, r_w;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_words_left;
  logic                      r_rdone;

  logic [AXI_ADDR_WIDTH-1:0] w_start;
  logic [AXI_ADDR_WIDTH-1:0] w_aligned;
  logic [LANE_W-1:0]         w_skip;
  logic [31:0]               w_words;
  logic [31:0]               w_to4k;
  logic [31:0]               w_beats;
  logic                      w_accept;
  logic                      w_r_hs;
  logic                      w_final;
  logic                      w_rx_en;
  logic                      w_word_ready;

  assign w_accept = req_valid && r_req_ready;
  assign w_r_hs   = axi_rvalid && axi_rready;
  assign w_final  = pix_valid && pix_ready && pix_last;
  // Only the single outstanding burst may deliver data.
  assign w_rx_en  = (r_state == StData) && !r_rdone;

  // Line geometry from the captured request and burst sizing from the current address.
  always_comb begin
    w_start   = r_base + AXI_ADDR_WIDTH'(r_y) * STRIDE_A + AXI_ADDR_WIDTH'(r_x) * BPP_A;
    w_aligned = w_start & ALIGN_MASK;
    w_skip    = LANE_W'(r_x % 16'(PIXS));
    w_words   = (32'(w_skip) + 32'(r_w) + 32'(PIXS) - 32'd1) / 32'(PIXS);
    w_to4k    = (32'd4096 - 32'(r_addr[11:0])) / 32'(BPW);
    w_beats   = r_words_left;
    if (w_beats > 32'(MAX_BURST)) w_beats = 32'(MAX_BURST);
    if (w_beats > w_to4k)         w_beats = w_to4k;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_nxt = StCalc;
      StCalc: w_state_nxt = (r_w == 16'd0) ? StIdle : StAddr;
      StAddr: if (axi_arready) w_state_nxt = StData;
      StData: begin
        if (r_rdone) begin
          if (w_final) w_state_nxt = StIdle;
        end else if (w_r_hs && axi_rlast && (r_words_left != 32'd0)) begin
          w_state_nxt = StAddr;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, request capture and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= StIdle;
      r_req_ready  <= 1'b0;
      r_base       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_w          <= '0;
      r_addr       <= '0;
      r_words_left <= '0;
      r_rdone      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == StIdle);
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_base <= req_base_addr;
            r_x    <= req_x;
            r_y    <= req_y;
            r_w    <= req_w;
          end
        end
        StCalc: begin
          r_addr       <= w_aligned;
          r_words_left <= w_words;
          r_rdone      <= 1'b0;
        end
        StAddr: begin
          if (axi_arready) begin
            r_addr       <= r_addr + AXI_ADDR_WIDTH'(w_beats * 32'(BPW));
            r_words_left <= r_words_left - w_beats;
          end
        end
        StData: begin
          if (w_r_hs && axi_rlast && (r_words_left == 32'd0)) r_rdone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign axi_arid    = AXI_ID_WIDTH'(AXI_ID);
  assign axi_arsize  = 3'(SIZE);
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arvalid = (r_state == StAddr);
  assign axi_araddr  = r_addr;
  assign axi_arlen   = (r_state == StAddr) ? 8'(w_beats - 32'd1) : 8'd0;
  assign axi_rready  = w_rx_en && w_word_ready;

  line_fetch_pix_unpack #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .PIX_WIDTH  (PIX_WIDTH),
    .LANE_W     (LANE_W)
  ) u_unpack (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (r_state == StCalc),
    .i_skip       (w_skip),
    .i_count      (r_w),
    .i_word       (axi_rdata),
    .i_word_valid (axi_rvalid && w_rx_en),
    .o_word_ready (w_word_ready),
    .o_pix_data   (pix_data),
    .o_pix_valid  (pix_valid),
    .o_pix_last   (pix_last),
    .i_pix_ready  (pix_ready)
  );

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch with default parameters. The AXI slave returns
// each 32-bit lane equal to its own byte address, so pixel k of a line must
// equal start_byte + 4*k.
module tb_line_fetch;

  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   req_base_addr;
  logic [15:0]   req_x, req_y, req_w;
  logic          req_valid, req_ready;
  logic [31:0]   pix_data;
  logic          pix_valid, pix_last, pix_ready;
  logic [7:0]    axi_arid;
  logic [31:0]   axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid, axi_arready;
  logic [DW-1:0] axi_rdata;
  logic          axi_rlast, axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  line_fetch dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_base_addr (req_base_addr),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_w         (req_w),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_last      (pix_last),
    .pix_ready     (pix_ready),
    .axi_arid      (axi_arid),
    .axi_araddr    (axi_araddr),
    .axi_arlen     (axi_arlen),
    .axi_arsize    (axi_arsize),
    .axi_arburst   (axi_arburst),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_rdata     (axi_rdata),
    .axi_rlast     (axi_rlast),
    .axi_rvalid    (axi_rvalid),
    .axi_rready    (axi_rready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [31:0] px_q[$];
  logic        px_last_q[$];
  int          hold_viol = 0;
  int          ar_overlap = 0;
  int          rdy_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // AXI read slave: one AR at a time, then len+1 beats of address-valued lanes.
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    axi_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      if (rstn && axi_arvalid) begin
        a = axi_araddr;
        l = axi_arlen;
        ar_addr_q.push_back(a);
        ar_len_q.push_back(l);
        axi_arready = 1'b1;
        @(posedge clk); #1;
        axi_arready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
          for (int i = 0; i < 8; i++) axi_rdata[i*32 +: 32] = a + 32'(32 * b) + 32'(4 * i);
          axi_rvalid = 1'b1;
          axi_rlast  = (b == int'(l));
          do begin
            @(negedge clk);
            if (axi_arvalid) ar_overlap++;
          end while (rstn && !axi_rready);
          if (!rstn) break;
          @(posedge clk); #1;
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
      end
    end
  end

  // pix_ready pattern: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'b0;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Pixel sink: collects accepted pixels and watches stability under stall.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!pix_valid || pix_data !== prev_d || pix_last !== prev_l))
          hold_viol++;
        if (pix_valid && pix_ready) begin
          px_q.push_back(pix_data);
          px_last_q.push_back(pix_last);
        end
        prev_stall = pix_valid && !pix_ready;
        prev_d     = pix_data;
        prev_l     = pix_last;
      end
    end
  end

  // Presents a request and returns #1 after the accepting edge.
  task automatic send_req(input logic [31:0] base, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] w);
    int n;
    ar_addr_q.delete();
    ar_len_q.delete();
    px_q.delete();
    px_last_q.delete();
    @(posedge clk); #1;
    req_base_addr = base;
    req_x         = x;
    req_y         = y;
    req_w         = w;
    req_valid     = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 64'(req_ready), 64'd1);
  endtask

  task automatic check_pixels(input string tag, input logic [31:0] start, input int w);
    int nbad;
    int n;
    nbad = 0;
    n = (px_q.size() < w) ? px_q.size() : w;
    check({tag, "_npix"}, 64'(px_q.size()), 64'(w));
    for (int k = 0; k < n; k++) begin
      if (px_q[k] !== start + 32'(4 * k)) nbad++;
      if (px_last_q[k] !== (k == w - 1)) nbad++;
    end
    check({tag, "_pixbad"}, 64'(nbad), 64'd0);
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [31:0] addr,
                          input logic [7:0] len);
    if (ar_addr_q.size() > idx) begin
      check({tag, "_araddr"}, 64'(ar_addr_q[idx]), 64'(addr));
      check({tag, "_arlen"}, 64'(ar_len_q[idx]), 64'(len));
    end else begin
      check({tag, "_ar_missing"}, 64'(ar_addr_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
    check({tag, "_pix_last"}, 64'(pix_last), 64'd0);
    check({tag, "_pix_data"}, 64'(pix_data), 64'd0);
    check({tag, "_arvalid"}, 64'(axi_arvalid), 64'd0);
    check({tag, "_rready"}, 64'(axi_rready), 64'd0);
    check({tag, "_araddr"}, 64'(axi_araddr), 64'd0);
    check({tag, "_arlen"}, 64'(axi_arlen), 64'd0);
  endtask

  initial begin
    int n;
    req_base_addr = '0;
    req_x         = '0;
    req_y         = '0;
    req_w         = '0;
    req_valid     = 1'b0;

    // Reset and release.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("arid", 64'(axi_arid), 64'd0);
    check("arsize", 64'(axi_arsize), 64'd5);
    check("arburst", 64'(axi_arburst), 64'd1);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_req_ready", 64'(req_ready), 64'd1);

    // One word: x=0, w=8; AR appears on the 2nd cycle after acceptance.
    rdy_mode = 0;
    send_req(32'd0, 16'd0, 16'd0, 16'd8);
    check("w8_calc_arvalid", 64'(axi_arvalid), 64'd0);
    @(posedge clk); #1;
    check("w8_arvalid", 64'(axi_arvalid), 64'd1);
    check("w8_araddr_live", 64'(axi_araddr), 64'd0);
    check("w8_arlen_live", 64'(axi_arlen), 64'd0);
    wait_done("w8");
    check("w8_nar", 64'(ar_addr_q.size()), 64'd1);
    check_pixels("w8", 32'd0, 8);

    // Skip of 3 lanes across two words, random back-pressure.
    rdy_mode = 2;
    send_req(32'd0, 16'd3, 16'd1, 16'd10);
    wait_done("x3");
    check("x3_nar", 64'(ar_addr_q.size()), 64'd1);
    check_ar("x3", 0, 32'd7680, 8'd1);
    check_pixels("x3", 32'd7692, 10);

    // 25 words: 16-beat burst then 9-beat burst, never overlapping.
    ar_overlap = 0;
    send_req(32'd0, 16'd0, 16'd0, 16'd200);
    wait_done("w200");
    check("w200_nar", 64'(ar_addr_q.size()), 64'd2);
    check_ar("w200_b0", 0, 32'd0, 8'd15);
    check_ar("w200_b1", 1, 32'd512, 8'd8);
    check("w200_overlap", 64'(ar_overlap), 64'd0);
    check_pixels("w200", 32'd0, 200);

    // 4 KB split with 4 words on each side of the boundary.
    rdy_mode = 0;
    send_req(32'd0, 16'd992, 16'd0, 16'd64);
    wait_done("x992");
    check_ar("x992_b0", 0, 32'd3968, 8'd3);
    check_ar("x992_b1", 1, 32'd4096, 8'd3);
    check_pixels("x992", 32'd3968, 64);

    // Start byte 4000 is word-aligned: 3 words before the boundary, 5 after.
    send_req(32'd0, 16'd1000, 16'd0, 16'd64);
    wait_done("x1000");
    check_ar("x1000_b0", 0, 32'd4000, 8'd2);
    check_ar("x1000_b1", 1, 32'd4096, 8'd4);
    check_pixels("x1000", 32'd4000, 64);

    // Nonzero base, skip 5, 4 words in one burst.
    send_req(32'h100, 16'd5, 16'd2, 16'd20);
    wait_done("base");
    check("base_nar", 64'(ar_addr_q.size()), 64'd1);
    check_ar("base", 0, 32'd15616, 8'd3);
    check_pixels("base", 32'd15636, 20);

    // Zero-width request: no AR, ready again two cycles after acceptance.
    send_req(32'd0, 16'd7, 16'd3, 16'd0);
    check("w0_calc_req_ready", 64'(req_ready), 64'd0);
    check("w0_calc_arvalid", 64'(axi_arvalid), 64'd0);
    @(posedge clk); #1;
    check("w0_req_ready", 64'(req_ready), 64'd1);
    check("w0_arvalid", 64'(axi_arvalid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("w0_nar", 64'(ar_addr_q.size()), 64'd0);
    check("w0_npix", 64'(px_q.size()), 64'd0);

    // Sink stalled: rready drops with the buffer full, nothing lost.
    rdy_mode = 1;
    send_req(32'h2000, 16'd0, 16'd0, 16'd16);
    repeat (30) @(posedge clk);
    #1;
    check("stall_rready", 64'(axi_rready), 64'd0);
    check("stall_pix_valid", 64'(pix_valid), 64'd1);
    check("stall_pix_data", 64'(pix_data), 64'h2000);
    check("stall_npix", 64'(px_q.size()), 64'd0);
    rdy_mode = 0;
    wait_done("stall");
    check_ar("stall", 0, 32'h2000, 8'd1);
    check_pixels("stall", 32'h2000, 16);

    // Reset pulsed mid-line.
    send_req(32'd0, 16'd0, 16'd0, 16'd200);
    n = 0;
    while (px_q.size() < 20 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_progress", 64'(px_q.size() >= 20), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rstn = 1'b1;
    @(posedge clk); #1;
    check("midrst_rel_req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);

    // Clean line after the abandoned one.
    send_req(32'd0, 16'd3, 16'd1, 16'd10);
    wait_done("post");
    check_ar("post", 0, 32'd7680, 8'd1);
    check_pixels("post", 32'd7692, 10);

    check("hold_stable", 64'(hold_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
